// File: rtl/gift_sbox_seq_if.sv
// Handshake bundle for gift_sbox_seq: input state channel and substituted-state output channel.
interface gift_sbox_seq_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gift_sbox_seq.sv
// Iterative GIFT S-box layer: substitutes LANES nibbles per cycle through a rotating shift register.
// Optional inverse S-box selection is enabled by defining GIFT_SBOX_INV_EN.
module gift_sbox_seq #(
  parameter int DATA_W = 64,
  parameter int LANES  = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef GIFT_SBOX_INV_EN
  input  logic inv,
`endif
  gift_sbox_seq_if.slave bus,
  output logic busy
);

  localparam int SLICE_W = 4 * LANES;
  localparam int N       = DATA_W / SLICE_W;
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;

  if ((LANES < 1) || (DATA_W % SLICE_W != 0)) begin : g_param_check
    $error("gift_sbox_seq: DATA_W must be a multiple of 4*LANES and LANES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SLICE_W-1:0] lane_out;
  logic [DATA_W-1:0]  substituted;
  logic               in_ready;
  logic               out_valid;
  logic               inv_q, inv_d;
  logic               inv_in;

`ifdef GIFT_SBOX_INV_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b0;
`endif

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h1;  4'h1: y = 4'ha;  4'h2: y = 4'h4;  4'h3: y = 4'hc;
      4'h4: y = 4'h6;  4'h5: y = 4'hf;  4'h6: y = 4'h3;  4'h7: y = 4'h9;
      4'h8: y = 4'h2;  4'h9: y = 4'hd;  4'ha: y = 4'hb;  4'hb: y = 4'h7;
      4'hc: y = 4'h5;  4'hd: y = 4'h0;  4'he: y = 4'h8;  default: y = 4'he;
    endcase
    return y;
  endfunction

`ifdef GIFT_SBOX_INV_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hd;  4'h1: y = 4'h0;  4'h2: y = 4'h8;  4'h3: y = 4'h6;
      4'h4: y = 4'h2;  4'h5: y = 4'hc;  4'h6: y = 4'h4;  4'h7: y = 4'hb;
      4'h8: y = 4'he;  4'h9: y = 4'h7;  4'ha: y = 4'h1;  4'hb: y = 4'ha;
      4'hc: y = 4'h3;  4'hd: y = 4'h9;  4'he: y = 4'hf;  default: y = 4'h5;
    endcase
    return y;
  endfunction
`endif

  always_comb begin
    lane_out = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef GIFT_SBOX_INV_EN
      lane_out[4*i +: 4] = inv_q ? sbox_inv(data_q[4*i +: 4]) : sbox_fwd(data_q[4*i +: 4]);
`else
      lane_out[4*i +: 4] = sbox_fwd(data_q[4*i +: 4]);
`endif
    end
  end

  // Shift-based rotate also covers N==1, where the shift clears the register and the lane fills it.
  assign substituted = (data_q >> SLICE_W) | ({{(DATA_W-SLICE_W){1'b0}}, lane_out} << (DATA_W - SLICE_W));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          inv_d   = inv_in;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy   = 1'b1;
        data_d = substituted;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            data_d  = bus.in_data;
            inv_d   = inv_in;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_gift_sbox_seq.sv
// Directed self-checking bench for gift_sbox_seq in three configurations (64/4, 64/1, 128/32).
module tb_gift_sbox_seq;

  logic clk;
  logic rst;
  logic busy_a, busy_b, busy_c;
  int   checks;
  int   errors;

  gift_sbox_seq_if #(.DATA_W(64))  a ();
  gift_sbox_seq_if #(.DATA_W(64))  b ();
  gift_sbox_seq_if #(.DATA_W(128)) c ();

`ifdef GIFT_SBOX_INV_EN
  logic inv_a, inv_b, inv_c;
`endif

  gift_sbox_seq #(.DATA_W(64), .LANES(4)) dut_a (
    .clk  (clk),
    .rst  (rst),
`ifdef GIFT_SBOX_INV_EN
    .inv  (inv_a),
`endif
    .bus  (a.slave),
    .busy (busy_a)
  );

  gift_sbox_seq #(.DATA_W(64), .LANES(1)) dut_b (
    .clk  (clk),
    .rst  (rst),
`ifdef GIFT_SBOX_INV_EN
    .inv  (inv_b),
`endif
    .bus  (b.slave),
    .busy (busy_b)
  );

  gift_sbox_seq #(.DATA_W(128), .LANES(32)) dut_c (
    .clk  (clk),
    .rst  (rst),
`ifdef GIFT_SBOX_INV_EN
    .inv  (inv_c),
`endif
    .bus  (c.slave),
    .busy (busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (a.out_valid !== 1'b0 || busy_a !== 1'b0 || a.out_data !== 64'h0 || a.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_a: got ov=%b busy=%b data=%h ir=%b expected 0 0 0 1",
               a.out_valid, busy_a, a.out_data, a.in_ready);
    end
    checks++;
    if (b.out_valid !== 1'b0 || busy_b !== 1'b0 || b.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_b: got ov=%b busy=%b ir=%b expected 0 0 1", b.out_valid, busy_b, b.in_ready);
    end
    checks++;
    if (c.out_valid !== 1'b0 || c.out_data !== 128'h0 || c.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_c: got ov=%b data=%h ir=%b expected 0 0 1", c.out_valid, c.out_data, c.in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    a.in_valid = 1'b1;
    a.in_data  = 64'h0123456789abcdef;
    tick();
    a.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_a !== 1'b1 || a.out_valid !== 1'b0 || a.in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL latency_busy_%0d: got busy=%b ov=%b ir=%b expected 1 0 0", i, busy_a, a.out_valid, a.in_ready);
      end
      tick();
    end
    checks++;
    if (a.out_valid !== 1'b1 || busy_a !== 1'b0 || a.out_data !== 64'h1a4c6f392db7508e) begin
      errors++;
      $display("[TB] FAIL latency_result: got ov=%b busy=%b data=%h expected 1 0 1a4c6f392db7508e",
               a.out_valid, busy_a, a.out_data);
    end
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_drain: got ov=%b ir=%b expected 0 1", a.out_valid, a.in_ready);
    end
  endtask

  task automatic run_b(input logic [63:0] din, input logic [63:0] exp, input string name);
    b.in_valid = 1'b1;
    b.in_data  = din;
    tick();
    b.in_valid = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    checks++;
    if (b.out_valid !== 1'b0 || busy_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_early: got ov=%b busy=%b expected 0 1", name, b.out_valid, busy_b);
    end
    tick();
    checks++;
    if (b.out_valid !== 1'b1 || b.out_data !== exp) begin
      errors++;
      $display("[TB] FAIL %s_result: got ov=%b data=%h expected 1 %h", name, b.out_valid, b.out_data, exp);
    end
    b.out_ready = 1'b1;
    tick();
    b.out_ready = 1'b0;
  endtask

  task automatic test_lanes1();
    run_b(64'h0000000000000000, 64'h1111111111111111, "lanes1_zero");
    run_b(64'hffffffffffffffff, 64'heeeeeeeeeeeeeeee, "lanes1_ones");
  endtask

  task automatic test_parallel();
    c.in_valid = 1'b1;
    c.in_data  = 128'h0123456789abcdef0123456789abcdef;
    tick();
    c.in_valid = 1'b0;
    checks++;
    if (busy_c !== 1'b1 || c.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL parallel_busy: got busy=%b ov=%b expected 1 0", busy_c, c.out_valid);
    end
    tick();
    checks++;
    if (c.out_valid !== 1'b1 || c.out_data !== 128'h1a4c6f392db7508e1a4c6f392db7508e) begin
      errors++;
      $display("[TB] FAIL parallel_result: got ov=%b data=%h expected 1 1a4c6f392db7508e1a4c6f392db7508e",
               c.out_valid, c.out_data);
    end
    c.out_ready = 1'b1;
    tick();
    c.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    a.in_valid = 1'b1;
    a.in_data  = 64'h0123456789abcdef;
    tick();
    a.in_data  = 64'hfedcba9876543210;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a.out_valid !== 1'b1 || a.in_ready !== 1'b0 || a.out_data !== 64'h1a4c6f392db7508e) begin
        errors++;
        $display("[TB] FAIL hold_%0d: got ov=%b ir=%b data=%h expected 1 0 1a4c6f392db7508e",
                 i, a.out_valid, a.in_ready, a.out_data);
      end
      tick();
    end
    a.out_ready = 1'b1;
    #1;
    checks++;
    if (a.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_ready: got ir=%b expected 1", a.in_ready);
    end
    @(posedge clk);
    #1;
    a.in_valid  = 1'b0;
    a.out_ready = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || a.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got busy=%b ov=%b expected 1 0", busy_a, a.out_valid);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (a.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_early: got ov=%b expected 0", a.out_valid);
    end
    tick();
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data !== 64'he8057bd293f6c4a1) begin
      errors++;
      $display("[TB] FAIL b2b_result: got ov=%b data=%h expected 1 e8057bd293f6c4a1", a.out_valid, a.out_data);
    end
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    a.in_valid = 1'b1;
    a.in_data  = 64'h0123456789abcdef;
    tick();
    a.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (a.out_valid !== 1'b0 || busy_a !== 1'b0 || a.out_data !== 64'h0 || a.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid: got ov=%b busy=%b data=%h ir=%b expected 0 0 0 1",
               a.out_valid, busy_a, a.out_data, a.in_ready);
    end
    a.in_valid = 1'b1;
    a.in_data  = 64'hffffffffffffffff;
    tick();
    a.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data !== 64'heeeeeeeeeeeeeeee) begin
      errors++;
      $display("[TB] FAIL reset_mid_after: got ov=%b data=%h expected 1 eeeeeeeeeeeeeeee", a.out_valid, a.out_data);
    end
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
  endtask

`ifdef GIFT_SBOX_INV_EN
  task automatic run_inv(input logic inv_sel, input logic [63:0] exp, input string name);
    a.in_valid = 1'b1;
    a.in_data  = 64'h1a4c6f392db7508e;
    inv_a      = inv_sel;
    tick();
    a.in_valid = 1'b0;
    inv_a      = ~inv_sel;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (a.out_valid !== 1'b1 || a.out_data !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got ov=%b data=%h expected 1 %h", name, a.out_valid, a.out_data, exp);
    end
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
  endtask

  task automatic test_inverse();
    run_inv(1'b1, 64'h0123456789abcdef, "inverse");
    run_inv(1'b0, 64'hab653ecd4079f128, "inverse_off_forward");
  endtask
`endif

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    a.in_valid  = 1'b0;  a.in_data = '0;  a.out_ready = 1'b0;
    b.in_valid  = 1'b0;  b.in_data = '0;  b.out_ready = 1'b0;
    c.in_valid  = 1'b0;  c.in_data = '0;  c.out_ready = 1'b0;
`ifdef GIFT_SBOX_INV_EN
    inv_a = 1'b0;
    inv_b = 1'b0;
    inv_c = 1'b0;
`endif
    test_reset();
    test_latency();
    test_lanes1();
    test_parallel();
    test_back_to_back();
    test_reset_mid();
`ifdef GIFT_SBOX_INV_EN
    test_inverse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gift_sbox_seq.md
Name: gift_sbox_seq

Overview:
- Iterative GIFT S-box layer for a full cipher state.
- Accepts a DATA_W-bit state over a valid/ready handshake.
- Substitutes LANES nibbles per clock, with the nibble rows processed low to high, and returns the substituted state over a valid/ready handshake.
- Used by the GIFT ISE datapath for the SubCells step of GIFT-64 (DATA_W=64) and GIFT-128 (DATA_W=128). LANES trades area against latency.

Parameters:
- DATA_W, 64, state width in bits. Must be a multiple of 4*LANES.
- LANES, 4, number of S-box instances, i.e. nibbles substituted per cycle. Legal values 1..DATA_W/4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a new state.
- in_data  in  DATA_W  input state; nibble i occupies bits [4i+3:4i].
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  DATA_W  substituted state.
- busy  out  1  high while in BUSY.

Behaviour:
- Definitions:
  - N = DATA_W/(4*LANES) processing cycles.
  - Forward S-box, values for inputs 0..f: 1,a,4,c,6,f,3,9,2,d,b,7,5,0,8,e.
- Reset (rst=1 at a rising edge): state←IDLE, data register←0, cycle counter←0. Resulting outputs: out_valid=0, busy=0, out_data=0. in_ready=1 from the first cycle after reset. rst overrides all other inputs, including mid-operation; any in-flight or unconsumed result is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load in_data into the shift register, set cnt←0, go to BUSY.
- BUSY (lasts N cycles):
  - Each cycle, substitute the low 4*LANES bits of the register through LANES S-boxes.
  - Write the result into the top 4*LANES bits while shifting the register right by 4*LANES.
  - cnt increments each cycle. On cnt==N-1, go to DONE.
  - in_ready=0. in_valid and in_data are ignored.
- DONE:
  - out_valid=1. out_data equals the register, which now holds the fully substituted state in original nibble order.
  - out_data is stable until the handshake completes.
  - On out_valid&out_ready: if in_valid is also high, load the new state and go to BUSY (back-to-back, no bubble). Otherwise go to IDLE.
  - in_ready = out_ready while in DONE. This is combinational; it is the only combinational in→out path.
  - If out_ready=0, hold indefinitely.
- Latency:
  - Accept at rising edge k → out_valid=1 after edge k+N.
  - Throughput: one state per N+1 cycles when the consumer is always ready.
- out_data is a registered output. Its value in states other than DONE is don't-care for consumers but deterministic (the register contents).
- N=1 (LANES=DATA_W/4): BUSY lasts exactly one cycle, so the design is fully parallel with one-cycle latency.
- Illegal parameters (DATA_W not a multiple of 4*LANES): an elaboration-time error is raised via a generate-time check.

Optional Feature:
- Macro GIFT_SBOX_INV_EN.
- When defined:
  - Adds input port inv (1 bit). It is sampled together with in_data on the accept handshake and held for the whole operation.
  - inv=1 selects the inverse S-box, values for inputs 0..f: d,0,8,6,2,c,4,b,e,7,1,a,3,9,f,5.
  - Timing is identical for both modes.
- When undefined: port inv is absent and only the forward S-box is instantiated.

Test Plan:
- DATA_W=64, LANES=4: reset, then in_data=0x0123456789abcdef → out_data=0x1a4c6f392db7508e, out_valid rising exactly 4 edges after accept; busy high for 4 cycles.
- DATA_W=64, LANES=1: in_data=0x0000000000000000 → 0x1111111111111111 after 16 cycles. Then 0xffffffffffffffff → 0xeeeeeeeeeeeeeeee.
- DATA_W=128, LANES=32: 0x0123456789abcdef0123456789abcdef → 0x1a4c6f392db7508e1a4c6f392db7508e with one-cycle latency.
- Backpressure and back-to-back: hold out_ready=0 for 10 cycles in DONE → out_data stable, in_ready=0. Then assert out_ready together with in_valid and a new state → new state accepted the same edge, and the next result appears N edges later.
- Reset mid-operation: assert rst at BUSY cycle 2 → next cycle out_valid=0, busy=0, out_data=0, in_ready=1. A subsequent operation produces the correct result.
- With GIFT_SBOX_INV_EN: inv=1, in_data=0x1a4c6f392db7508e → 0x0123456789abcdef. Then inv=0 on the same data yields the forward mapping.
